// File: rtl/roi_downsampler.sv
// roi_downsampler
//
// Reduces a 112x112 RGB565 ROI pixel stream to a 28x28 8-bit grayscale image
// by 4x4 box averaging. The image is held in an internal 784-byte buffer and,
// once the frame is complete, streamed out in raster order over valid/ready.
//
// Build option:
//   ROI_DS_ROUND_EN  defined   -> block average rounds to nearest ((sum+8)>>4)
//                    undefined -> block average truncates (sum>>4)
//
// Ports:
//   pixel_clk  in   1   pixel clock, all logic on the rising edge
//   rst        in   1   synchronous active-high reset
//   roi_pixel  in  16   RGB565 pixel, R[15:11] G[10:5] B[4:0]
//   roi_x      in   7   ROI column 0..111
//   roi_y      in   7   ROI row 0..111
//   roi_valid  in   1   qualifies roi_pixel/roi_x/roi_y (no backpressure)
//   ds_data    out  8   output gray byte
//   ds_valid   out  1   ds_data valid
//   ds_ready   in   1   byte accepted when ds_valid && ds_ready
//   ds_last    out  1   high with byte index 783
//   busy       out  1   high while capturing or sending
//   frame_err  out  1   one-cycle pulse when a capture restarts early

module roi_downsampler (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [15:0] roi_pixel,
    input  logic [6:0]  roi_x,
    input  logic [6:0]  roi_y,
    input  logic        roi_valid,
    output logic [7:0]  ds_data,
    output logic        ds_valid,
    input  logic        ds_ready,
    output logic        ds_last,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SEND
    } state_t;

    localparam int unsigned NUM_BYTES = 784;
    localparam int unsigned BLK_W     = 28;
    localparam logic [9:0]  LAST_IDX  = 10'd783;

    state_t state_q, state_d;

    // Input qualification
    logic start_pix;
    logic end_pix;
    logic accept;
    logic restart;
    logic closing_q;   // final pixel taken; drop input until SEND is entered

    // Stage 1: gray conversion
    logic [7:0]  r8, g8, b8;
    logic [15:0] gray_sum;
    logic [7:0]  gray_d;
    logic        s1_valid_q;
    logic [7:0]  s1_gray_q;
    logic [4:0]  s1_bx_q;
    logic [4:0]  s1_by_q;
    logic        s1_first_q;  // top-left pixel of a block
    logic        s1_last_q;   // bottom-right pixel of a block

    // Stage 2: accumulation and block write
    logic [11:0] acc [BLK_W];
    logic [11:0] blk_sum;
    logic [11:0] blk_rnd;
    logic [7:0]  blk_avg;
    logic [9:0]  wr_addr;
    logic        final_blk;
    logic        done_q;

    // Image buffer and readout
    logic [7:0]  mem [NUM_BYTES];
    logic [9:0]  rd_addr;
    logic [9:0]  pf_idx_q;    // buffer index currently held in rdata_q
    logic [7:0]  rdata_q;
    logic        pf_valid_q;
    logic        load_out;
    logic        out_done;

    assign busy = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Input qualification
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        start_pix = 1'b0;
        end_pix   = 1'b0;
        accept    = 1'b0;
        restart   = 1'b0;
        start_pix = roi_valid && (roi_x == 7'd0) && (roi_y == 7'd0);
        end_pix   = (roi_x == 7'd111) && (roi_y == 7'd111);
        if (roi_valid) begin
            if (state_q == ST_IDLE) begin
                accept = start_pix;
            end else if (state_q == ST_CAPTURE && !closing_q) begin
                accept  = 1'b1;
                restart = start_pix;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start_pix) state_d = ST_CAPTURE;
            ST_CAPTURE: if (done_q)    state_d = ST_SEND;
            ST_SEND:    if (out_done)  state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            closing_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            done_q     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= accept;
            frame_err  <= restart;
            done_q     <= s1_valid_q && s1_last_q && final_blk;
            if (state_q != ST_CAPTURE) begin
                closing_q <= 1'b0;
            end else if (accept && end_pix) begin
                closing_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: RGB565 -> 8-bit gray (truncating)
    // ------------------------------------------------------------------
    always_comb begin
        r8       = {roi_pixel[15:11], roi_pixel[15:13]};
        g8       = {roi_pixel[10:5],  roi_pixel[10:9]};
        b8       = {roi_pixel[4:0],   roi_pixel[4:2]};
        // Weights sum to 256, so the maximum is 255*256 and fits 16 bits.
        gray_sum = 16'd77  * {8'd0, r8}
                 + 16'd150 * {8'd0, g8}
                 + 16'd29  * {8'd0, b8};
        gray_d   = 8'(gray_sum >> 8);
    end

    // NOTE: pure datapath registers, the accumulators and the buffer carry no
    // reset; they are always qualified by a reset-cleared valid/state bit,
    // and leaving them unreset lets the buffer map onto block RAM.
    always_ff @(posedge pixel_clk) begin
        s1_gray_q  <= gray_d;
        s1_bx_q    <= roi_x[6:2];
        s1_by_q    <= roi_y[6:2];
        s1_first_q <= (roi_x[1:0] == 2'd0) && (roi_y[1:0] == 2'd0);
        s1_last_q  <= (roi_x[1:0] == 2'd3) && (roi_y[1:0] == 2'd3);
    end

    // ------------------------------------------------------------------
    // Stage 2: per-column accumulators for the current block row
    // ------------------------------------------------------------------
    always_comb begin
        // 16 pixels of at most 255 sum to 4080, so 12 bits never overflow,
        // including the rounding offset (4088).
        blk_sum = acc[s1_bx_q] + {4'd0, s1_gray_q};
`ifdef ROI_DS_ROUND_EN
        blk_rnd = blk_sum + 12'd8;
`else
        blk_rnd = blk_sum;
`endif
        blk_avg   = 8'(blk_rnd >> 4);
        wr_addr   = 10'(s1_by_q) * 10'd28 + 10'(s1_bx_q);
        final_blk = (s1_bx_q == 5'd27) && (s1_by_q == 5'd27);
    end

    always_ff @(posedge pixel_clk) begin
        if (s1_valid_q) begin
            if (s1_first_q) begin
                acc[s1_bx_q] <= {4'd0, s1_gray_q};
            end else begin
                acc[s1_bx_q] <= blk_sum;
            end
            if (s1_last_q) begin
                mem[wr_addr] <= blk_avg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Readout: synchronous buffer read into a prefetch register, then an
    // output register. The prefetch already holds the next byte, so a
    // handshake can reload the output every cycle.
    // ------------------------------------------------------------------
    always_comb begin
        out_done = ds_valid && ds_ready && ds_last;
        load_out = (state_q == ST_SEND) && pf_valid_q &&
                   (!ds_valid || (ds_ready && !ds_last));
        rd_addr  = pf_idx_q;
        if (load_out && pf_idx_q != LAST_IDX) begin
            rd_addr = pf_idx_q + 10'd1;
        end
    end

    always_ff @(posedge pixel_clk) begin
        rdata_q <= mem[rd_addr];
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            pf_idx_q   <= 10'd0;
            pf_valid_q <= 1'b0;
            ds_data    <= 8'd0;
            ds_valid   <= 1'b0;
            ds_last    <= 1'b0;
        end else if (state_q != ST_SEND) begin
            pf_idx_q   <= 10'd0;
            pf_valid_q <= 1'b0;
            ds_valid   <= 1'b0;
            ds_last    <= 1'b0;
        end else begin
            pf_idx_q   <= rd_addr;
            pf_valid_q <= 1'b1;
            if (load_out) begin
                ds_data  <= rdata_q;
                ds_valid <= 1'b1;
                ds_last  <= (pf_idx_q == LAST_IDX);
            end else if (out_done) begin
                ds_valid <= 1'b0;
                ds_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_roi_downsampler.sv
// Testbench for roi_downsampler: frames are built in an array, the expected
// 28x28 image is derived from them with plain arithmetic and queued, and an
// independent monitor compares every output byte against the queue.

module tb_roi_downsampler;

    logic        pixel_clk = 1'b0;
    logic        rst;
    logic [15:0] roi_pixel;
    logic [6:0]  roi_x;
    logic [6:0]  roi_y;
    logic        roi_valid;
    logic [7:0]  ds_data;
    logic        ds_valid;
    logic        ds_ready;
    logic        ds_last;
    logic        busy;
    logic        frame_err;

    roi_downsampler dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .roi_pixel (roi_pixel),
        .roi_x     (roi_x),
        .roi_y     (roi_y),
        .roi_valid (roi_valid),
        .ds_data   (ds_data),
        .ds_valid  (ds_valid),
        .ds_ready  (ds_ready),
        .ds_last   (ds_last),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    int         n_checks = 0;
    int         n_fails  = 0;
    int         frame_err_cnt = 0;
    int         ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    int         frame [12544];
    logic [8:0] exp_q [$];        // {last, data}

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int gray_of(input int p);
        int r5, g6, b5, r8, g8, b8;
        r5 = (p >> 11) & 31;
        g6 = (p >> 5) & 63;
        b5 = p & 31;
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return (77 * r8 + 150 * g8 + 29 * b8) / 256;
    endfunction

    task automatic push_expected();
        int sum, avg;
        logic [8:0] e;
        for (int by = 0; by < 28; by++) begin
            for (int bx = 0; bx < 28; bx++) begin
                sum = 0;
                for (int dy = 0; dy < 4; dy++)
                    for (int dx = 0; dx < 4; dx++)
                        sum += gray_of(frame[(by * 4 + dy) * 112 + bx * 4 + dx]);
`ifdef ROI_DS_ROUND_EN
                avg = (sum + 8) / 16;
`else
                avg = sum / 16;
`endif
                e = {(by == 27 && bx == 27) ? 1'b1 : 1'b0, 8'(avg)};
                exp_q.push_back(e);
            end
        end
    endtask

    // ---------------- frame builders ----------------
    task automatic fill_const(input int p);
        for (int i = 0; i < 12544; i++) frame[i] = p;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 12544; i++) frame[i] = int'($urandom_range(0, 65535));
    endtask

    // Block (0,0): its top two rows white, everything else black.
    task automatic fill_half_block();
        fill_const(0);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) frame[y * 112 + x] = 16'hFFFF;
    endtask

    // Each block carries a gray-ish colour scaled from its raster index.
    task automatic fill_pattern();
        int v;
        for (int y = 0; y < 112; y++) begin
            for (int x = 0; x < 112; x++) begin
                v = ((y / 4) * 28 + (x / 4)) % 256;
                frame[y * 112 + x] = ((v / 8) << 11) | ((v / 4) << 5) | (v / 8);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic send_frame(input int rows, input bit lat_check, input bit tail_starts);
        int k, v;
        @(posedge pixel_clk); #1;
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < 112; x++) begin
                if ($urandom_range(0, 63) == 0) begin
                    roi_valid = 1'b0;
                    roi_x     = 7'($urandom);
                    roi_y     = 7'($urandom);
                    roi_pixel = 16'($urandom);
                    @(posedge pixel_clk); #1;
                end
                roi_valid = 1'b1;
                roi_x     = 7'(x);
                roi_y     = 7'(y);
                roi_pixel = 16'(frame[y * 112 + x]);
                @(posedge pixel_clk); #1;
            end
        end
        // Start pixels right behind the final one belong to no frame.
        if (tail_starts) begin
            repeat (3) begin
                roi_valid = 1'b1;
                roi_x     = 7'd0;
                roi_y     = 7'd0;
                roi_pixel = 16'hFFFF;
                @(posedge pixel_clk); #1;
            end
        end
        roi_valid = 1'b0;
        if (lat_check) begin
            // Now in cycle N+1 of the final pixel; ds_valid first at N+5.
            k = 1;
            @(negedge pixel_clk);
            while (!ds_valid && k < 30) begin
                @(negedge pixel_clk);
                k++;
            end
            check("first_valid_latency", k, 5);
            v = 0;
            while (ds_valid && v < 2000) begin
                v++;
                @(negedge pixel_clk);
            end
            check("valid_burst_len", v, 784);
        end
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 0;
        @(negedge pixel_clk);
        while (busy && budget < 30000) begin
            @(negedge pixel_clk);
            budget++;
        end
        check({name, "_busy_fall"}, busy, 0);
        check({name, "_all_bytes_out"}, exp_q.size(), 0);
    endtask

    // ---------------- ready driver ----------------
    initial begin
        ds_ready = 1'b0;
        forever begin
            @(posedge pixel_clk); #1;
            case (ready_mode)
                0:       ds_ready = 1'b1;
                1:       ds_ready = ($urandom_range(0, 3) != 0);
                default: ds_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge pixel_clk) begin
        if (!rst) begin
            if (frame_err) frame_err_cnt++;
            if (ds_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_byte: got data %0d last %0d with nothing expected",
                             ds_data, ds_last);
                end else if (ds_ready) begin
                    check("ds_byte", {ds_last, ds_data}, exp_q.pop_front());
                end else begin
                    check("ds_stall_hold", {ds_last, ds_data}, exp_q[0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1500000;
        n_fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int err_before;
        rst       = 1'b1;
        roi_valid = 1'b0;
        roi_x     = 7'd0;
        roi_y     = 7'd0;
        roi_pixel = 16'd0;
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        check("rst_ds_data", ds_data, 0);
        check("rst_ds_valid", ds_valid, 0);
        check("rst_ds_last", ds_last, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        @(posedge pixel_clk); #1;
        rst = 1'b0;

        // Partial frame abandoned by reset.
        fill_random();
        send_frame(10, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge pixel_clk); #1;
        @(negedge pixel_clk);
        check("midrst_busy", busy, 0);
        check("midrst_ds_valid", ds_valid, 0);
        @(posedge pixel_clk); #1;
        rst = 1'b0;

        // White frame, sustained output.
        ready_mode = 0;
        fill_const(16'hFFFF);
        push_expected();
        send_frame(112, 1'b1, 1'b0);
        wait_idle("white");
        check("white_ds_last_after", ds_last, 0);

        // Block (0,0) half white.
        fill_half_block();
        push_expected();
        send_frame(112, 1'b0, 1'b0);
        wait_idle("half_block");

        // Restart after 50 rows, then a patterned frame with random ready.
        ready_mode = 1;
        err_before = frame_err_cnt;
        fill_random();
        send_frame(50, 1'b0, 1'b0);
        fill_pattern();
        push_expected();
        send_frame(112, 1'b0, 1'b0);
        wait_idle("restart_pattern");
        check("restart_frame_err_pulses", frame_err_cnt - err_before, 1);

        // Red frame held in SEND while another frame is pushed and dropped.
        ready_mode = 2;
        err_before = frame_err_cnt;
        fill_const(16'hF800);
        push_expected();
        send_frame(112, 1'b0, 1'b1);
        fill_random();
        send_frame(112, 1'b0, 1'b0);
        repeat (200) @(negedge pixel_clk);
        check("stall_busy", busy, 1);
        check("stall_ds_valid", ds_valid, 1);
        check("stall_no_frame_err", frame_err_cnt - err_before, 0);
        ready_mode = 0;
        wait_idle("stalled_red");

        // Third frame after the stall: black.
        fill_const(0);
        push_expected();
        send_frame(112, 1'b0, 1'b0);
        wait_idle("black");
        check("final_frame_err_total", frame_err_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
